mem_stage_sized: RTL
====================

# mem_stage_sized

Parametrised successor to the pipeline's data-memory stage. It adds byte, halfword and word loads and stores, sign or zero extension on loads, configurable depth, and configurable wait states behind a busy/done handshake. Sits between the EX/MEM pipeline register and the write-back mux. The datapath is little-endian and 32 bits wide. Memory contents are not reset.

## Interface
Parameters:
- ADDR_BITS, 10, word-index width; depth = 2^ADDR_BITS words
- WAIT_STATES, 0, extra cycles inserted before each access (0..15)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- Mem_WrEn  in  1  store request (sampled only in IDLE)
- Mem_RdEn  in  1  load request (sampled only in IDLE)
- Mem_Size  in  2  00 byte, 01 half, 10 word, 11 reserved
- Mem_Signed  in  1  1 = sign-extend loads, 0 = zero-extend
- ALU_MEM_Addr  in  32  byte address
- MEM_DataIn  in  32  store data; low byte/half used for sub-word stores
- MEM_DataOut  out  32  load result; held until next load completes
- Mem_Busy  out  1  high while a request is in flight
- Mem_Done  out  1  one-cycle pulse on completion (load or store)
- Mem_Err  out  1  one-cycle pulse with Mem_Done on a rejected access

## Operation
- State machine: IDLE, WAIT, ACCESS.
- IDLE: if Mem_WrEn or Mem_RdEn is high, latch the address, data, size, signed flag and direction.
  - If WAIT_STATES = 0, go to ACCESS; otherwise load the counter with WAIT_STATES-1 and go to WAIT.
- WAIT: decrement the counter; go to ACCESS when the counter is 0.
- ACCESS: commit the store, or register the load result into MEM_DataOut; pulse Mem_Done; return to IDLE.
- Mem_WrEn and Mem_RdEn both high: treated as a store; the read is dropped.
- Word index = addr[ADDR_BITS+1:2]. Upper address bits are ignored, so the address wraps modulo 4·2^ADDR_BITS bytes.
- Store lanes:
  - Byte: writes MEM_DataIn[7:0] to byte lane addr[1:0].
  - Half: writes MEM_DataIn[15:0] to lanes {addr[1],0} and {addr[1],1}.
  - Word: writes all four lanes.
  - Unselected lanes are unchanged.
- Load extract: select the byte or half by the same lanes, then extend to 32 bits per Mem_Signed. Mem_Signed is ignored for word loads.
- Requests presented while Mem_Busy is high are ignored. Requesters must wait for Mem_Busy low.
- Reset: state returns to IDLE and any in-flight store is aborted (no write). Outputs reset to MEM_DataOut=0, Mem_Busy=0, Mem_Done=0, Mem_Err=0.

## Timing
- Request sampled at the edge closing IDLE cycle N.
- Mem_Busy (state≠IDLE) is high in cycles N+1 .. N+1+WAIT_STATES.
- Mem_Done and MEM_DataOut are valid in cycle N+2+WAIT_STATES. The block is in IDLE in that same cycle and can accept the next request.
- Throughput: one access per WAIT_STATES+2 cycles.
- A store is visible to a load accepted in the cycle Mem_Done is high.
- Mem_Busy is registered. It must not depend combinationally on the request inputs.

## Configuration
- MEM_STAGE_MISALIGN_TRAP_EN defined:
  - Half with addr[0]=1, word with addr[1:0]≠0, or Mem_Size=11 is rejected.
  - A rejected access runs the normal handshake, suppresses the write and leaves MEM_DataOut unchanged.
  - Mem_Err pulses together with Mem_Done.
- MEM_STAGE_MISALIGN_TRAP_EN undefined:
  - Mem_Err is tied to 0 and size 11 is treated as word.
  - Misaligned accesses are forced aligned: half ignores addr[0]; word ignores addr[1:0].

## Structure
- Shared package mem_pkg holds:
  - size encodings MEM_BYTE/MEM_HALF/MEM_WORD/MEM_RSVD
  - state enum IDLE/WAIT/ACCESS
  - the fixed data width 32
- One sub-module, mem_lane_align: a combinational block producing the store byte-enable/replicated data and the load extract/extend.
- The memory array and FSM live in the top.

## Test plan
- WAIT_STATES=0: store word 0x0000001F at addr 4, then load word at addr 4 → Mem_Done in cycle N+2, MEM_DataOut=0x0000001F.
- Store word 0xAABBCCDD at addr 8, then load signed byte at addr 9 → 0xFFFFFFCC; load unsigned half at addr 10 → 0x0000AABB.
- Store byte 0x10 at addr 1 over word 0x0000001F at addr 0, then load word at addr 0 → 0x0000101F.
- WAIT_STATES=3: load → Mem_Busy high for exactly 4 cycles and Mem_Done 5 cycles after the request edge; a second request raised during Busy is ignored.
- With MEM_STAGE_MISALIGN_TRAP_EN: store word at addr 0xFC3 → Mem_Err and Mem_Done pulse, word index 0x3F0 unchanged. Without the macro: the same store writes word index 0x3F0 (ADDR_BITS=10).
- Reset asserted during WAIT of a store → no write occurs, all outputs 0, and the next load returns the prior contents.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the sized data-memory stage: access sizes, FSM states,
// datapath width and the alignment rule used when misaligned accesses trap.
package mem_pkg;

   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      MEM_BYTE = 2'b00,
      MEM_HALF = 2'b01,
      MEM_WORD = 2'b10,
      MEM_RSVD = 2'b11
   } mem_size_e;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      ACCESS
   } mem_state_e;

   // Reserved size never has a legal alignment.
   function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] offset);
      case (size)
         MEM_BYTE: return 1'b0;
         MEM_HALF: return offset[0];
         MEM_WORD: return offset != 2'b00;
         default:  return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane steering: store byte-enables and replicated store data,
// plus load byte/half extraction with sign or zero extension.
module mem_lane_align
   import mem_pkg::*;
(
   input  mem_size_e         size,
   input  logic              sign_ext,
   input  logic [1:0]        offset,
   input  logic [DATA_W-1:0] st_data,
   input  logic [DATA_W-1:0] ld_word,
   output logic [3:0]        st_be,
   output logic [DATA_W-1:0] st_word,
   output logic [DATA_W-1:0] ld_data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign byte_sel = ld_word[{offset, 3'b000} +: 8];
   assign half_sel = offset[1] ? ld_word[31:16] : ld_word[15:0];

   // Word and reserved sizes fall through to the full-word defaults, which is
   // also what forces misaligned words onto their aligned word.
   always_comb begin
      // NOTE: every output gets a default before the case so no latch is inferred.
      st_be   = 4'b1111;
      st_word = st_data;
      ld_data = ld_word;
      case (size)
         MEM_BYTE: begin
            st_be   = 4'b0001 << offset;
            st_word = {4{st_data[7:0]}};
            ld_data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
         end
         MEM_HALF: begin
            st_be   = offset[1] ? 4'b1100 : 4'b0011;
            st_word = {2{st_data[15:0]}};
            ld_data = {{16{sign_ext & half_sel[15]}}, half_sel};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_stage_sized.sv
// Data-memory stage with byte/half/word access, WAIT_STATES latency and a
// busy/done handshake. Define MEM_STAGE_MISALIGN_TRAP_EN to reject misaligned accesses.
module mem_stage_sized
   import mem_pkg::*;
#(
   parameter int ADDR_BITS   = 10,
   parameter int WAIT_STATES = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              Mem_WrEn,
   input  logic              Mem_RdEn,
   input  logic [1:0]        Mem_Size,
   input  logic              Mem_Signed,
   input  logic [DATA_W-1:0] ALU_MEM_Addr,
   input  logic [DATA_W-1:0] MEM_DataIn,
   output logic [DATA_W-1:0] MEM_DataOut,
   output logic              Mem_Busy,
   output logic              Mem_Done,
   output logic              Mem_Err
);

   localparam int         DEPTH     = 1 << ADDR_BITS;
   localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   mem_state_e             state_q, state_d;
   logic [3:0]             cnt_q, cnt_d;
   logic [ADDR_BITS+1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]      wdata_q, wdata_d;
   mem_size_e              size_q, size_d;
   logic                   sign_q, sign_d;
   logic                   wr_q, wr_d;
   logic [DATA_W-1:0]      dout_q, dout_d;
   logic                   done_q, done_d;
   logic                   reject;
   logic                   mem_we;

   logic [DATA_W-1:0]      mem_q [DEPTH];
   logic [ADDR_BITS-1:0]   word_idx;
   logic [3:0]             st_be;
   logic [DATA_W-1:0]      st_word;
   logic [DATA_W-1:0]      ld_data;
   logic                   unused_addr;

   assign unused_addr = ^ALU_MEM_Addr[DATA_W-1:ADDR_BITS+2];
   assign word_idx    = addr_q[ADDR_BITS+1:2];

   mem_lane_align u_align (
      .size     (size_q),
      .sign_ext (sign_q),
      .offset   (addr_q[1:0]),
      .st_data  (wdata_q),
      .ld_word  (mem_q[word_idx]),
      .st_be    (st_be),
      .st_word  (st_word),
      .ld_data  (ld_data)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      size_d  = size_q;
      sign_d  = sign_q;
      wr_d    = wr_q;
      dout_d  = dout_q;
      done_d  = 1'b0;
      mem_we  = 1'b0;
      case (state_q)
         IDLE: begin
            if (Mem_WrEn || Mem_RdEn) begin
               addr_d  = ALU_MEM_Addr[ADDR_BITS+1:0];
               wdata_d = MEM_DataIn;
               size_d  = mem_size_e'(Mem_Size);
               sign_d  = Mem_Signed;
               wr_d    = Mem_WrEn;
               if (WAIT_STATES == 0) begin
                  state_d = ACCESS;
               end else begin
                  cnt_d   = WAIT_LOAD;
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) state_d = ACCESS;
            else               cnt_d   = cnt_q - 4'd1;
         end
         ACCESS: begin
            done_d  = 1'b1;
            state_d = IDLE;
            // A reset landing on the commit edge still aborts the store.
            mem_we  = wr_q && !reject && !reset;
            if (!wr_q && !reject) dout_d = ld_data;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         dout_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dout_q  <= dout_d;
         done_q  <= done_d;
      end
   end

   always_ff @(posedge clk) begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
      wr_q    <= wr_d;
   end

   // NOTE: the memory array has no reset; clearing it would cost a full sweep.
   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (mem_we && st_be[b]) mem_q[word_idx][8*b +: 8] <= st_word[8*b +: 8];
      end
   end

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
   logic err_q, err_d;

   assign reject = is_misaligned(size_q, addr_q[1:0]);

   always_comb begin
      err_d = (state_q == ACCESS) && reject;
   end

   always_ff @(posedge clk) begin
      if (reset) err_q <= 1'b0;
      else       err_q <= err_d;
   end

   assign Mem_Err = err_q;
`else
   assign reject  = 1'b0;
   assign Mem_Err = 1'b0;
`endif

   assign MEM_DataOut = dout_q;
   assign Mem_Busy    = (state_q != IDLE);
   assign Mem_Done    = done_q;

endmodule
